// File: rtl/window_pkg.sv
// Shared types and helpers for the line-buffer window controller.
// No ports; provides the read FSM state type, a width helper for counters,
// the window bit-offset function and the ring-index wrap used for buffer select.
package window_pkg;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bit offset of window element (row r, column offset k).
  function automatic int win_offset(input int r, input int k, input int ksize, input int pix_w);
    return (r * ksize + k) * pix_w;
  endfunction

  // (base + off) mod n, valid for base < n and off < n.
  function automatic int ring_idx(input int base, input int off, input int n);
    return (base + off >= n) ? (base + off - n) : (base + off);
  endfunction

endpackage

// File: rtl/window_line_ram.sv
// One line buffer: simple dual-port RAM, one write port, one synchronous
// read port whose output register only updates when re is high.
// Ports:
//   clk          clock
//   we/waddr/wdata  write enable, address, data
//   re/raddr     read enable and address
//   rdata        registered read data (holds while re is low)
module line_ram #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/window_line_ctrl.sv
// Line-buffer controller: writes a raster pixel stream into a ring of NBUF
// line RAMs and, once KSIZE lines are stored, emits one KSIZE x KSIZE window
// per column with right-edge replicate padding.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_pixel_data/valid, o_pixel_ready   input pixel stream handshake
//   o_window, o_window_valid, i_window_ready  window stream handshake;
//                                 slice (r*KSIZE+k)*PIX_W = row r (0 oldest), column k
//   o_line_done                   pulse after the last window of a row is accepted
//   o_lines_stored                complete lines not yet released
//
// state   | meaning
// RD_IDLE | waiting for KSIZE complete lines
// RD_READ | issuing column reads and emitting the windows of one output row
module window_line_ctrl
  import window_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 512,
  parameter int KSIZE = 3,
  parameter int NBUF  = KSIZE + 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [PIX_W-1:0]               i_pixel_data,
  input  logic                           i_pixel_valid,
  output logic                           o_pixel_ready,
  output logic [PIX_W*KSIZE*KSIZE-1:0]   o_window,
  output logic                           o_window_valid,
  input  logic                           i_window_ready,
  output logic                           o_line_done,
  output logic [$clog2(NBUF+1)-1:0]      o_lines_stored
);

  localparam int AW     = idx_width(IMG_W);
  localparam int COL_W  = idx_width(IMG_W + KSIZE - 1);
  localparam int BUF_W  = idx_width(NBUF);
  localparam int FILL_W = idx_width(KSIZE);
  localparam int CNT_W  = $clog2(NBUF + 1);
  localparam int WIN_W  = PIX_W * KSIZE * KSIZE;

  localparam logic [AW-1:0]     COL_LAST  = AW'(IMG_W - 1);
  localparam logic [COL_W-1:0]  RD_LAST   = COL_W'(IMG_W + KSIZE - 2);
  localparam logic [COL_W-1:0]  RD_CLAMP  = COL_W'(IMG_W - 1);
  localparam logic [BUF_W-1:0]  BUF_LAST  = BUF_W'(NBUF - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(KSIZE - 1);
  localparam logic [CNT_W-1:0]  CNT_NBUF  = CNT_W'(NBUF);
  localparam logic [CNT_W-1:0]  CNT_K     = CNT_W'(KSIZE);

  rd_state_t state_q, state_d;

  logic [CNT_W-1:0]  lines_q;
  logic [AW-1:0]     wr_col_q;
  logic [BUF_W-1:0]  wr_buf_q;
  logic [BUF_W-1:0]  rd_base_q;
  logic [COL_W-1:0]  rd_col_q;
  logic              rd_vld_q;
  logic [FILL_W-1:0] fill_q;
  logic [AW-1:0]     win_cnt_q;
  logic [WIN_W-1:0]  win_q;
  logic              win_vld_q;
  logic              line_done_q;

  logic              accept;
  logic              wr_eol;
  logic              adv;
  logic              issue;
  logic              rd_en;
  logic              row_done;
  logic [AW-1:0]     rd_addr;
  logic [PIX_W-1:0]  ram_rdata [NBUF];
  logic [PIX_W-1:0]  col_data  [KSIZE];

  assign o_pixel_ready  = (lines_q < CNT_NBUF);
  assign accept         = i_pixel_valid & o_pixel_ready;
  assign wr_eol         = accept && (wr_col_q == COL_LAST);
  assign adv            = !win_vld_q || i_window_ready;
  assign row_done       = win_vld_q && i_window_ready && (win_cnt_q == COL_LAST);
  // Columns past the right edge re-read the last pixel: replicate padding.
  assign rd_addr        = (rd_col_q > RD_CLAMP) ? AW'(RD_CLAMP) : AW'(rd_col_q);

  assign o_window       = win_q;
  assign o_window_valid = win_vld_q;
  assign o_line_done    = line_done_q;
  assign o_lines_stored = lines_q;

  for (genvar g = 0; g < NBUF; g++) begin : g_ram
    line_ram #(
      .PIX_W (PIX_W),
      .DEPTH (IMG_W),
      .AW    (AW)
    ) u_ram (
      .clk   (i_clk),
      .we    (accept && (wr_buf_q == BUF_W'(g))),
      .waddr (wr_col_q),
      .wdata (i_pixel_data),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (ram_rdata[g])
    );
  end

  // Row r of the window comes from buffer rd_base + r in the ring.
  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      col_data[r] = ram_rdata[BUF_W'(ring_idx(int'(rd_base_q), r, NBUF))];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= RD_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (lines_q >= CNT_K) state_d = RD_READ;
      end
      RD_READ: begin
        issue = (rd_col_q <= RD_LAST);
        if (row_done) state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
    rd_en = adv && issue;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_col_q <= '0;
      wr_buf_q <= '0;
    end else if (accept) begin
      if (wr_col_q == COL_LAST) begin
        wr_col_q <= '0;
        wr_buf_q <= (wr_buf_q == BUF_LAST) ? '0 : wr_buf_q + BUF_W'(1);
      end else begin
        wr_col_q <= wr_col_q + AW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lines_q <= '0;
    end else begin
      case ({wr_eol, row_done})
        2'b10:   lines_q <= lines_q + CNT_W'(1);
        2'b01:   lines_q <= lines_q - CNT_W'(1);
        default: lines_q <= lines_q;
      endcase
    end
  end

  // Read pipeline: issue -> RAM output (rd_vld_q) -> column shift register.
  // Every stage moves only on adv, so a stalled window stays put.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_base_q   <= '0;
      rd_col_q    <= '0;
      rd_vld_q    <= 1'b0;
      fill_q      <= '0;
      win_cnt_q   <= '0;
      win_q       <= '0;
      win_vld_q   <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      line_done_q <= row_done;
      if (win_vld_q && i_window_ready) win_cnt_q <= win_cnt_q + AW'(1);
      if (adv) begin
        rd_vld_q <= issue;
        if (issue) rd_col_q <= rd_col_q + COL_W'(1);
        // A window is complete once KSIZE-1 columns are already held.
        win_vld_q <= rd_vld_q && (fill_q == FILL_FULL);
        if (rd_vld_q) begin
          if (fill_q != FILL_FULL) fill_q <= fill_q + FILL_W'(1);
          for (int r = 0; r < KSIZE; r++) begin
            for (int k = 0; k < KSIZE - 1; k++) begin
              win_q[win_offset(r, k, KSIZE, PIX_W) +: PIX_W] <=
                win_q[win_offset(r, k + 1, KSIZE, PIX_W) +: PIX_W];
            end
            win_q[win_offset(r, KSIZE - 1, KSIZE, PIX_W) +: PIX_W] <= col_data[r];
          end
        end
      end
      if (row_done) begin
        rd_base_q <= (rd_base_q == BUF_LAST) ? '0 : rd_base_q + BUF_W'(1);
        rd_col_q  <= '0;
        rd_vld_q  <= 1'b0;
        fill_q    <= '0;
        win_cnt_q <= '0;
        win_q     <= '0;
        win_vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_line_ctrl.sv
// Directed bench: dut_a is 3x3 on 8-pixel lines, dut_b is 5x5 on 16-pixel lines.
// Pixel value = IMG_W*line + column, so every window is predictable.
module tb_window_line_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        a_rst, a_pv, a_prdy, a_wv, a_wr, a_ld;
  logic [7:0]  a_pix;
  logic [71:0] a_win;
  logic [2:0]  a_ls;

  logic         b_rst, b_pv, b_prdy, b_wv, b_wr, b_ld, b_thr;
  logic [7:0]   b_pix;
  logic [199:0] b_win;
  logic [2:0]   b_ls;

  window_line_ctrl #(.PIX_W(8), .IMG_W(8), .KSIZE(3), .NBUF(4)) dut_a (
    .i_clk          (clk),
    .i_rst          (a_rst),
    .i_pixel_data   (a_pix),
    .i_pixel_valid  (a_pv),
    .o_pixel_ready  (a_prdy),
    .o_window       (a_win),
    .o_window_valid (a_wv),
    .i_window_ready (a_wr),
    .o_line_done    (a_ld),
    .o_lines_stored (a_ls)
  );

  window_line_ctrl #(.PIX_W(8), .IMG_W(16), .KSIZE(5), .NBUF(6)) dut_b (
    .i_clk          (clk),
    .i_rst          (b_rst),
    .i_pixel_data   (b_pix),
    .i_pixel_valid  (b_pv),
    .o_pixel_ready  (b_prdy),
    .o_window       (b_win),
    .o_window_valid (b_wv),
    .i_window_ready (b_wr),
    .o_line_done    (b_ld),
    .o_lines_stored (b_ls)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Window n of output row 'row': element (r,k) = pixel(row+r, min(n+k, w-1)).
  function automatic logic [255:0] exp_win(input int row, input int n, input int ks, input int w);
    logic [255:0] v;
    v = '0;
    for (int r = 0; r < ks; r++) begin
      for (int k = 0; k < ks; k++) begin
        int c;
        c = (n + k > w - 1) ? (w - 1) : (n + k);
        v[(r * ks + k) * 8 +: 8] = 8'(w * (row + r) + c);
      end
    end
    return v;
  endfunction

  int          a_row = 0, a_col = 0, a_nwin = 0, a_ld_cnt = 0;
  logic        a_ld_prev = 1'b0;
  logic [71:0] a_cap [8][8];

  initial begin
    forever begin
      @(negedge clk);
      if (a_rst) begin
        a_row = 0; a_col = 0; a_ld_prev = 1'b0;
      end else begin
        if (a_ld) begin
          check("a_line_done_pulse", 256'(a_ld_prev), 256'(0));
          a_ld_cnt++;
        end
        a_ld_prev = a_ld;
        if (!a_prdy) check("a_ready_low_only_full", 256'(a_ls), 256'(4));
        if (a_wv && a_wr) begin
          check($sformatf("a_win_r%0d_c%0d", a_row, a_col), 256'(a_win), exp_win(a_row, a_col, 3, 8));
          if (a_row < 8) a_cap[a_row][a_col] = a_win;
          a_nwin++;
          if (a_col == 7) begin a_col = 0; a_row++; end
          else a_col++;
        end
      end
    end
  end

  int           b_row = 0, b_col = 0, b_nwin = 0, b_ld_cnt = 0;
  logic [199:0] b_w0, b_w15;

  initial begin
    forever begin
      @(negedge clk);
      if (b_rst) begin
        b_row = 0; b_col = 0;
      end else begin
        if (b_ld) b_ld_cnt++;
        if (b_wv && b_wr) begin
          check($sformatf("b_win_r%0d_c%0d", b_row, b_col), 256'(b_win), exp_win(b_row, b_col, 5, 16));
          if (b_row == 0 && b_col == 0)  b_w0  = b_win;
          if (b_row == 0 && b_col == 15) b_w15 = b_win;
          b_nwin++;
          if (b_col == 15) begin b_col = 0; b_row++; end
          else b_col++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (b_thr) b_wr = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // Push tasks are entered just after a rising edge and return just after the
  // edge that accepted the pixel.
  task automatic a_push(input logic [7:0] v);
    int g;
    g = 0;
    a_pix = v; a_pv = 1'b1;
    @(negedge clk);
    while (!a_prdy && g < 2000) begin @(negedge clk); g++; end
    if (!a_prdy) check("a_push_timeout", 256'(a_prdy), 256'(1));
    @(posedge clk); #1;
    a_pv = 1'b0;
  endtask

  task automatic b_push(input logic [7:0] v);
    int g;
    g = 0;
    if (b_thr) begin
      b_pv = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    b_pix = v; b_pv = 1'b1;
    @(negedge clk);
    while (!b_prdy && g < 2000) begin @(negedge clk); g++; end
    if (!b_prdy) check("b_push_timeout", 256'(b_prdy), 256'(1));
    @(posedge clk); #1;
    b_pv = 1'b0;
  endtask

  task automatic wait_ld_a(input int n, input string tag);
    int g;
    g = 0;
    while (a_ld_cnt < n && g < 1000) begin @(negedge clk); g++; end
    check(tag, 256'(a_ld_cnt >= n), 256'(1));
  endtask

  task automatic wait_ld_b(input int n, input string tag);
    int g;
    g = 0;
    while (b_ld_cnt < n && g < 3000) begin @(negedge clk); g++; end
    check(tag, 256'(b_ld_cnt >= n), 256'(1));
  endtask

  task automatic reset_a();
    a_rst = 1'b1; a_pv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0;
    a_nwin = 0; a_ld_cnt = 0;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) a_cap[r][c] = '0;
  endtask

  task automatic run_basic(input string tag);
    a_nwin = 0; a_ld_cnt = 0; a_wr = 1'b1;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) a_cap[r][c] = '0;
    for (int l = 0; l < 3; l++) for (int c = 0; c < 8; c++) a_push(8'(8 * l + c));
    check({tag, "_lines_3"}, 256'(a_ls), 256'(3));
    wait_ld_a(1, {tag, "_row_done"});
    repeat (3) @(negedge clk);
    check({tag, "_lines_2"}, 256'(a_ls), 256'(2));
    check({tag, "_done_count"}, 256'(a_ld_cnt), 256'(1));
    check({tag, "_win_count"}, 256'(a_nwin), 256'(8));
    check({tag, "_w0_row0"}, 256'(a_cap[0][0][23:0]), 256'(24'h020100));
    check({tag, "_w7_row2"}, 256'(a_cap[0][7][71:48]), 256'(24'h171717));
    @(posedge clk); #1;
  endtask

  task automatic b_run(input logic thr, input string tag);
    b_rst = 1'b1; b_pv = 1'b0; b_thr = 1'b0; b_wr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    b_rst = 1'b0;
    b_nwin = 0; b_ld_cnt = 0; b_w0 = '0; b_w15 = '0;
    b_thr = thr;
    for (int l = 0; l < 6; l++) for (int c = 0; c < 16; c++) b_push(8'(16 * l + c));
    wait_ld_b(2, {tag, "_rows_done"});
    b_thr = 1'b0; b_wr = 1'b1;
    repeat (5) @(negedge clk);
    check({tag, "_win_count"}, 256'(b_nwin), 256'(32));
    check({tag, "_done_count"}, 256'(b_ld_cnt), 256'(2));
    check({tag, "_lines"}, 256'(b_ls), 256'(4));
    check({tag, "_w0_row0"}, 256'(b_w0[39:0]), 256'(40'h0403020100));
    check({tag, "_w15_row4"}, 256'(b_w15[199:160]), 256'(40'h4F4F4F4F4F));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [71:0] held;
    int g;
    a_rst = 1'b1; a_pv = 1'b0; a_pix = '0; a_wr = 1'b1;
    b_rst = 1'b1; b_pv = 1'b0; b_pix = '0; b_wr = 1'b1; b_thr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    check("rst_win_valid", 256'(a_wv), 256'(0));
    check("rst_lines", 256'(a_ls), 256'(0));
    check("rst_line_done", 256'(a_ld), 256'(0));
    check("rst_window", 256'(a_win), 256'(0));
    check("rst_ready", 256'(a_prdy), 256'(1));
    @(posedge clk); #1;

    run_basic("s1");

    reset_a();
    a_wr = 1'b1;
    for (int l = 0; l < 6; l++) for (int c = 0; c < 8; c++) a_push(8'(8 * l + c));
    wait_ld_a(4, "s2_rows_done");
    repeat (20) @(negedge clk);
    check("s2_done_count", 256'(a_ld_cnt), 256'(4));
    check("s2_win_count", 256'(a_nwin), 256'(32));
    check("s2_lines", 256'(a_ls), 256'(2));
    check("s2_r1_w0_row0", 256'(a_cap[1][0][23:0]), 256'(24'h0A0908));
    @(posedge clk); #1;

    fork
      for (int c = 0; c < 8; c++) a_push(8'(48 + c));
      begin
        g = 0;
        while (!(a_wv && a_col == 3) && g < 400) begin @(posedge clk); #1; g++; end
        check("s3_reach_w3", 256'(a_wv && a_col == 3), 256'(1));
        a_wr = 1'b0;
        held = a_win;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("s3_stall_valid", 256'(a_wv), 256'(1));
          check("s3_stall_hold", 256'(a_win), 256'(held));
        end
        @(posedge clk); #1;
        a_wr = 1'b1;
      end
    join
    wait_ld_a(5, "s3_row_done");
    repeat (3) @(negedge clk);
    check("s3_win_count", 256'(a_nwin), 256'(40));
    check("s3_lines", 256'(a_ls), 256'(2));
    @(posedge clk); #1;

    reset_a();
    a_wr = 1'b0;
    for (int i = 0; i < 32; i++) a_push(8'(i));
    check("s4_ready_low", 256'(a_prdy), 256'(0));
    check("s4_lines_full", 256'(a_ls), 256'(4));
    fork
      a_push(8'd32);
      begin
        repeat (8) @(posedge clk);
        #1;
        check("s4_ready_held", 256'(a_prdy), 256'(0));
        check("s4_no_row_yet", 256'(a_ld_cnt), 256'(0));
        a_wr = 1'b1;
      end
    join
    check("s4_resume_after_done", 256'(a_ld_cnt), 256'(1));

    reset_a();
    a_wr = 1'b1;
    for (int i = 0; i < 21; i++) a_push(8'(i));
    check("s5_lines_pre", 256'(a_ls), 256'(2));
    a_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0;
    check("s5_win_valid", 256'(a_wv), 256'(0));
    check("s5_lines", 256'(a_ls), 256'(0));
    check("s5_ready", 256'(a_prdy), 256'(1));
    run_basic("s5");

    b_run(1'b0, "s6_plain");
    b_run(1'b1, "s6_throttled");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
